// File: rtl/gat_pkg.sv
// Shared constants for the GAT layer sequencer: FSM state codes, default
// layer/latency parameters and the word-to-byte address shift.
package gat_pkg;

   localparam int DEF_NUM_LAYERS  = 2;
   localparam int DEF_BRAM_RD_LAT = 2;
   localparam int BYTE_SHIFT      = 2;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_LOAD = 3'd1;
   localparam logic [2:0] ST_RUN       = 3'd2;
   localparam logic [2:0] ST_DRAIN     = 3'd3;
   localparam logic [2:0] ST_NEXT      = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;
   localparam logic [2:0] ST_ERROR     = 3'd6;

endpackage

// File: rtl/gat_seq_skid_fifo.sv
// Small register-based FIFO that absorbs BRAM read data while the output
// stream is back-pressured. Data output is forced to zero when empty.
module gat_seq_skid_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             do_pop;

   assign do_pop  = pop_i && (cnt_q != '0);
   assign valid_o = (cnt_q != '0);
   assign data_o  = valid_o ? mem_q[rd_q] : '0;
   assign count_o = cnt_q;

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
         if (do_pop) rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
         case ({push_i, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Read credits upstream guarantee a full FIFO is never pushed without a pop.
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push_i && !do_pop && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/gat_layer_sequencer.sv
// Multi-layer GAT sequencer: gates host load flags into the core, waits for
// the core's layer-complete edge, drains the feature BRAM to a stream.
module gat_layer_sequencer
   import gat_pkg::*;
#(
   parameter int NEW_FEATURE_DEPTH  = 43328,
   parameter int NEW_FEATURE_WIDTH  = 32,
   parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
   parameter int NUM_LAYERS         = DEF_NUM_LAYERS,
   parameter int BRAM_RD_LAT        = DEF_BRAM_RD_LAT,
   parameter int FIFO_DEPTH         = 4,
   parameter int TIMEOUT_CYCLES     = 2**24
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     host_start,
   input  logic                                     host_h_data_load_done,
   input  logic                                     host_h_node_info_load_done,
   input  logic                                     host_wgt_load_done,
   output logic                                     core_h_data_bram_load_done,
   output logic                                     core_h_node_info_bram_load_done,
   output logic                                     core_wgt_bram_load_done,
   output logic                                     gat_layer,
   input  logic                                     gat_ready,
   output logic [NEW_FEATURE_ADDR_W+BYTE_SHIFT-1:0] feat_bram_addrb,
   input  logic [NEW_FEATURE_WIDTH-1:0]             feat_bram_dout,
   output logic [NEW_FEATURE_WIDTH-1:0]             feat_tdata,
   output logic                                     feat_tvalid,
   input  logic                                     feat_tready,
   output logic                                     feat_tlast,
   output logic                                     layer_req,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     err_timeout
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int ADDR_W = NEW_FEATURE_ADDR_W;
   localparam int BA_W   = NEW_FEATURE_ADDR_W + BYTE_SHIFT;

   logic [2:0]             state_q, state_d;
   logic                   layer_q;
   logic                   seen_low_q, wgt_low_q, all_iss_q;
   logic [TO_W-1:0]        to_cnt_q;
   logic [ADDR_W-1:0]      rd_idx_q, pop_idx_q;
   logic [BRAM_RD_LAT:0]   vld_pipe_q;
   logic [BA_W-1:0]        addr_q;
   logic                   core_en_q, layer_req_q, done_q, busy_q, err_q;
   logic [CNT_W-1:0]       fifo_cnt;
   logic [CNT_W:0]         occ;
   logic                   load_ok, issue, pop, last_word;

   assign pop       = feat_tvalid && feat_tready;
   assign last_word = (pop_idx_q == ADDR_W'(NEW_FEATURE_DEPTH - 1));
   assign load_ok   = host_h_data_load_done && host_h_node_info_load_done &&
                      host_wgt_load_done && (!layer_q || wgt_low_q);

   // Occupancy = words already buffered plus reads still in the BRAM pipe.
   always_comb begin
      occ = (CNT_W + 1)'(fifo_cnt);
      for (int i = 0; i <= BRAM_RD_LAT; i++) occ = occ + (CNT_W + 1)'(vld_pipe_q[i]);
      issue = (state_q == ST_DRAIN) && !all_iss_q && (occ < (CNT_W + 1)'(FIFO_DEPTH));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (host_start) state_d = ST_WAIT_LOAD;
         ST_WAIT_LOAD: if (load_ok) state_d = ST_RUN;
         ST_RUN: begin
            if (seen_low_q && gat_ready) state_d = ST_DRAIN;
            else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = ST_ERROR;
         end
         ST_DRAIN:     if (pop && last_word) state_d = ST_NEXT;
         ST_NEXT:      state_d = (layer_q == 1'(NUM_LAYERS - 1)) ? ST_DONE : ST_WAIT_LOAD;
         ST_DONE:      state_d = ST_IDLE;
         ST_ERROR:     if (host_start) state_d = ST_WAIT_LOAD;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         layer_q     <= 1'b0;
         seen_low_q  <= 1'b0;
         wgt_low_q   <= 1'b0;
         to_cnt_q    <= '0;
         rd_idx_q    <= '0;
         pop_idx_q   <= '0;
         all_iss_q   <= 1'b0;
         vld_pipe_q  <= '0;
         addr_q      <= '0;
         core_en_q   <= 1'b0;
         layer_req_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;

         if (state_d == ST_DONE || ((state_q == ST_IDLE || state_q == ST_ERROR) && host_start))
            layer_q <= 1'b0;
         else if (state_q == ST_NEXT && state_d == ST_WAIT_LOAD)
            layer_q <= layer_q + 1'b1;

         // Completion needs a low sample inside RUN before the high one.
         seen_low_q <= (state_q == ST_RUN) && (seen_low_q || !gat_ready);
         wgt_low_q  <= (state_q == ST_WAIT_LOAD) && (wgt_low_q || !host_wgt_load_done);

         if (state_q != ST_RUN) to_cnt_q <= '0;
         else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES - 1)) to_cnt_q <= to_cnt_q + 1'b1;

         vld_pipe_q <= {vld_pipe_q[BRAM_RD_LAT-1:0], issue};
         if (state_q != ST_DRAIN) begin
            rd_idx_q  <= '0;
            pop_idx_q <= '0;
            all_iss_q <= 1'b0;
         end else begin
            if (issue) begin
               addr_q <= BA_W'(rd_idx_q) << BYTE_SHIFT;
               if (rd_idx_q == ADDR_W'(NEW_FEATURE_DEPTH - 1)) all_iss_q <= 1'b1;
               else rd_idx_q <= rd_idx_q + 1'b1;
            end
            if (pop && !last_word) pop_idx_q <= pop_idx_q + 1'b1;
         end

         core_en_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         layer_req_q <= (state_q == ST_NEXT) && (state_d == ST_WAIT_LOAD);
         done_q      <= (state_d == ST_DONE);
         busy_q      <= !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERROR);
         err_q       <= (state_d == ST_ERROR);
      end
   end

   gat_seq_skid_fifo #(
      .WIDTH (NEW_FEATURE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (vld_pipe_q[BRAM_RD_LAT]),
      .data_i  (feat_bram_dout),
      .pop_i   (pop),
      .data_o  (feat_tdata),
      .valid_o (feat_tvalid),
      .count_o (fifo_cnt)
   );

   assign feat_tlast                      = feat_tvalid && last_word;
   assign core_h_data_bram_load_done      = core_en_q;
   assign core_h_node_info_bram_load_done = core_en_q;
   assign core_wgt_bram_load_done         = core_en_q;
   assign gat_layer                       = layer_q;
   assign feat_bram_addrb                 = addr_q;
   assign layer_req                       = layer_req_q;
   assign done                            = done_q;
   assign busy                            = busy_q;
   assign err_timeout                     = err_q;

endmodule
